// File: rtl/detect_bound_pkg.sv
// Shared types and constants for the multi-word bound detector.
// The optional polarity feature is controlled by DETECT_BOUND_POLARITY_EN in the top.
package detect_bound_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DONE
   } state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Pixel index width: row word number concatenated with the in-word position.
   function automatic int calc_idx_w(input int len_w, input int data_w);
      return len_w + $clog2(data_w);
   endfunction

endpackage

// File: rtl/bound_prio_enc.sv
// Single-word priority encoder: MSB-first for left scans, LSB-first for right scans.
module bound_prio_enc
   import detect_bound_pkg::*;
#(
   parameter int   DATA_W = 32,
   localparam int  POS_W  = $clog2(DATA_W)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic              dir_i,
   output logic [POS_W-1:0]  pos_o,
   output logic              hit_o
);

   always_comb begin
      pos_o = '0;
      hit_o = |data_i;
      if (dir_i == DIR_LEFT) begin
         // Ascending loop so the highest set bit is the last assignment.
         for (int i = 0; i < DATA_W; i++) begin
            if (data_i[i]) pos_o = POS_W'(i);
         end
      end else begin
         for (int i = DATA_W - 1; i >= 0; i--) begin
            if (data_i[i]) pos_o = POS_W'(i);
         end
      end
   end

endmodule

// File: rtl/detect_bound_scan.sv
// Scans a row of BRAM words and reports the leftmost/rightmost active pixel.
// Define DETECT_BOUND_POLARITY_EN to add i_polarity (search for 0-bits when low).
module detect_bound_scan
   import detect_bound_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  ADDR_W = 13,
   parameter int  LEN_W  = 8,
   localparam int IDX_W  = calc_idx_w(LEN_W, DATA_W)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_trig,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_num_words,
   input  logic              i_left_or_right,
`ifdef DETECT_BOUND_POLARITY_EN
   input  logic              i_polarity,
`endif
   output logic              o_bram_en,
   output logic [ADDR_W-1:0] o_bram_addr,
   input  logic [DATA_W-1:0] i_bram_rdata,
   output logic              o_busy,
   output logic [IDX_W-1:0]  o_bound_index,
   output logic              o_is_bound_detected,
   output logic              o_done
);

   localparam int POS_W = $clog2(DATA_W);

   state_e            state_q;
   logic              dir_q;
   logic [LEN_W-1:0]  num_q;
   logic [LEN_W-1:0]  issue_cnt_q;
   logic [LEN_W-1:0]  eval_idx_q;
   logic              eval_vld_q;
   logic [ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]  bound_q;
   logic              det_q;

   logic [DATA_W-1:0] enc_data;
   logic [POS_W-1:0]  enc_pos;
   logic              enc_hit;
   logic              hit_now;
   logic              last_eval;
   logic              issue;
   logic [LEN_W-1:0]  word_idx;

`ifdef DETECT_BOUND_POLARITY_EN
   logic pol_q;
   assign enc_data = pol_q ? i_bram_rdata : ~i_bram_rdata;
`else
   assign enc_data = i_bram_rdata;
`endif

   bound_prio_enc #(.DATA_W(DATA_W)) u_enc (
      .data_i (enc_data),
      .dir_i  (dir_q),
      .pos_o  (enc_pos),
      .hit_o  (enc_hit)
   );

   assign hit_now   = eval_vld_q && enc_hit;
   assign last_eval = eval_vld_q && (eval_idx_q == num_q - LEN_W'(1));
   // Next read is suppressed as soon as the word in hand hits.
   assign issue     = (issue_cnt_q < num_q) && !hit_now;
   assign word_idx  = (dir_q == DIR_RIGHT) ? (num_q - LEN_W'(1) - eval_idx_q) : eval_idx_q;

   assign o_bram_en           = (state_q == FETCH) && issue;
   assign o_bram_addr         = addr_q;
   assign o_busy              = (state_q != IDLE);
   assign o_done              = (state_q == DONE);
   assign o_bound_index       = bound_q;
   assign o_is_bound_detected = det_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         dir_q       <= DIR_LEFT;
         num_q       <= '0;
         issue_cnt_q <= '0;
         eval_idx_q  <= '0;
         eval_vld_q  <= 1'b0;
         addr_q      <= '0;
         bound_q     <= '0;
         det_q       <= 1'b0;
`ifdef DETECT_BOUND_POLARITY_EN
         pol_q       <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (i_trig) begin
                  dir_q       <= i_left_or_right;
                  num_q       <= i_num_words;
                  issue_cnt_q <= '0;
                  eval_vld_q  <= 1'b0;
`ifdef DETECT_BOUND_POLARITY_EN
                  pol_q       <= i_polarity;
`endif
                  if (i_num_words == '0) begin
                     state_q <= DONE;
                     bound_q <= '0;
                     det_q   <= 1'b0;
                  end else begin
                     state_q <= FETCH;
                     addr_q  <= (i_left_or_right == DIR_RIGHT) ?
                                i_base_addr + ADDR_W'(i_num_words) - ADDR_W'(1) : i_base_addr;
                  end
               end
            end
            FETCH: begin
               eval_vld_q <= issue;
               if (issue) begin
                  addr_q      <= (dir_q == DIR_RIGHT) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                  issue_cnt_q <= issue_cnt_q + LEN_W'(1);
                  eval_idx_q  <= issue_cnt_q;
               end
               if (hit_now || last_eval) begin
                  state_q <= DONE;
                  det_q   <= hit_now;
                  // DATA_W-1-b equals ~b because DATA_W is a power of two.
                  bound_q <= hit_now ? {word_idx, ~enc_pos} : '0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/detect_bound_scan.md
# detect_bound_scan

Multi-word bound detector for the connected-domain filter. A single trigger scans a row of `i_num_words` consecutive BRAM words, fetching them itself, and reports the pixel position of the leftmost or rightmost active pixel in the whole row. It is the parametrised successor of the single-word bound detector: word width, row length and address width are generic. It sits between the row-buffer BRAM and the domain-labelling control FSM.

## Interface
Parameters:
- `DATA_W`, 32: bits per BRAM word. Must be a power of two, ≥ 2.
- `ADDR_W`, 13: BRAM address width.
- `LEN_W`, 8: width of the word-count input. A row holds at most 2^LEN_W−1 words.
- `IDX_W`, LEN_W+$clog2(DATA_W): derived, not overridable. Width of the pixel index.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_trig` in 1: start pulse. Sampled only in IDLE.
- `i_base_addr` in ADDR_W: address of word 0 of the row.
- `i_num_words` in LEN_W: number of words in the row.
- `i_left_or_right` in 1: 0 = find the leftmost pixel, 1 = find the rightmost pixel.
- `o_bram_en` out 1: BRAM read enable.
- `o_bram_addr` out ADDR_W: BRAM read address. The BRAM has 1-cycle read latency.
- `i_bram_rdata` in DATA_W: BRAM read data.
- `o_busy` out 1: high from trigger accept until `o_done`.
- `o_bound_index` out IDX_W: pixel position of the bound.
- `o_is_bound_detected` out 1: 1 if an active pixel was found.
- `o_done` out 1: 1-cycle pulse; results are valid in the same cycle.

## Operation
- Pixel order inside a word:
  - Bit DATA_W−1 is the leftmost pixel.
  - The pixel position of bit b in row word w is w·DATA_W + (DATA_W−1−b).
- Left mode:
  - Words are scanned base → base+N−1.
  - Each word is encoded MSB-first. The first active bit found wins.
- Right mode:
  - Words are scanned base+N−1 → base.
  - Each word is encoded LSB-first. The first active bit found wins.
- "Active" means the bit equals 1 (see Configuration for the polarity option).
- FSM states: IDLE, FETCH, DONE.
- IDLE → FETCH when `i_trig`=1 and `i_num_words`≠0. The inputs are latched on this edge.
- IDLE → DONE when `i_trig`=1 and `i_num_words`=0. This produces a no-hit result without any BRAM access.
- FETCH:
  - One address is issued per cycle, and the data of the previous address is evaluated in the same cycle.
  - Exit to DONE on the first hit or after evaluating the last word.
  - At most one speculative read past the hit word is issued. It is never issued beyond the row.
- DONE: `o_done`=1 for one cycle, then return to IDLE.
- Addresses are computed modulo 2^ADDR_W, so base+N−1 may wrap past 0.
- A trigger while busy is ignored.
- No hit: `o_is_bound_detected`=0 and `o_bound_index`=0.
- `o_bound_index` and `o_is_bound_detected` are updated in the DONE cycle. They hold until the next DONE.

## Timing
- Cycle 0 is the cycle in which `i_trig` is sampled high in IDLE.
- Scan word k (k counted from 0, in scan order) is addressed in cycle k+1 and evaluated in cycle k+2.
- `o_done` is high in cycle k+3, where k is the hit word, or N−1 if there is no hit.
- `o_done` is high in cycle 1 for N=0.
- Back-to-back operation: a trigger is accepted in the cycle after `o_done`.
- Reset values: `o_bram_en`=0, `o_bram_addr`=0, `o_busy`=0, `o_done`=0, `o_bound_index`=0, `o_is_bound_detected`=0, state = IDLE.
- Reset asserted mid-scan aborts the operation immediately. No `o_done` is produced.

## Configuration
- Macro: `DETECT_BOUND_POLARITY_EN`.
- When defined:
  - An extra port `i_polarity` (in, 1 bit) is added and latched at trigger accept.
  - `i_polarity`=1 searches for 1-bits; `i_polarity`=0 searches for 0-bits. The data word is inverted before encoding.
- When undefined: the port does not exist and the block searches for 1-bits only.

## Structure
- Package `detect_bound_pkg` holds:
  - the FSM state enum (IDLE/FETCH/DONE);
  - the direction constants DIR_LEFT=0 and DIR_RIGHT=1;
  - a function computing IDX_W from LEN_W and DATA_W.
- Sub-module `bound_prio_enc`:
  - Parameter DATA_W.
  - Inputs: data, direction.
  - Outputs: bit position (width $clog2(DATA_W)) and hit flag.
  - Purely combinational; instantiated once.

## Test plan
All scenarios use DATA_W=32. Scenarios 1–2 use base 0x100, N=4, words [0, 0, 0x0080_0000, 0xFFFF_FFFF].
1. Left mode → index 72, detected=1, `o_done` in cycle 5.
2. Right mode → index 127, detected=1, `o_done` in cycle 3, exactly one BRAM read (0x103).
3. Three zero words at base 0x100 → detected=0, index 0, `o_done` in cycle 5, reads 0x100–0x102 only. Repeat with base 0x1FFF, N=2 → reads 0x1FFF then 0x0000.
4. N=0 → `o_done` in cycle 1, `o_bram_en` never asserted. A pulse on `i_trig` during a busy scan is ignored and the running result is unchanged.
5. `i_rst` asserted in cycle 2 of a scan → all outputs 0 immediately, no `o_done`. A new trigger after release completes normally.
6. With `DETECT_BOUND_POLARITY_EN`, `i_polarity`=0, left mode, N=1, word 0xFFFF_FFFE → index 31, detected=1.
